// File: rtl/rx_prbs_ber_checker.sv
// rx_prbs_ber_checker: QPSK PRBS9 receive checker.
// Decimates the oversampled I/Q samples at a chosen phase and slices each
// branch to one bit. A per-branch FSM self-synchronises a local PRBS9 and
// grants lock. While both branches are locked, decisions and bit errors are
// counted for BER measurement.
// Build option: define RX_BER_SAT_EN to make the counters saturate at
// all-ones. When it is left undefined, the counters wrap.

// Per-branch PRBS9 synchroniser and lock tracker.
module rx_prbs_ber_branch #(
  parameter int LOCK_WINDOW  = 511,
  parameter int LOCK_ERR_MAX = 32
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_enable,
  input  logic dec_vld,
  input  logic rx_bit,
  output logic lock,
  output logic mis
);

  typedef enum logic {LOAD, CHECK} state_t;

  localparam int WW = $clog2(LOCK_WINDOW + 1);

  state_t        state;
  logic [8:0]    lfsr;
  logic [3:0]    load_cnt;
  logic [WW-1:0] win_cnt;
  logic [WW-1:0] win_err;
  logic          pred;
  logic [8:0]    lfsr_load;
  logic [WW:0]   err_tot;

  // x^9+x^5+1 : the next bit is the bit from 9 decisions ago XOR the bit from 5 decisions ago
  assign pred      = lfsr[8] ^ lfsr[4];
  assign lfsr_load = {lfsr[7:0], rx_bit};
  assign mis       = (state == CHECK) && (rx_bit != pred);
  assign err_tot   = {1'b0, win_err} + {{WW{1'b0}}, mis};

  // LOAD fills the LFSR from the line; CHECK free-runs the LFSR and scores each window
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state    <= LOAD;
      lfsr     <= '0;
      load_cnt <= '0;
      win_cnt  <= '0;
      win_err  <= '0;
      lock     <= 1'b0;
    end else if (i_enable && dec_vld) begin
      case (state)
        LOAD: begin
          lfsr <= lfsr_load;
          if (load_cnt == 4'd8) begin
            load_cnt <= '0;
            // An all-zero seed would lock the LFSR up, so collect nine fresh bits again
            if (lfsr_load != 9'd0) begin
              state   <= CHECK;
              win_cnt <= '0;
              win_err <= '0;
            end
          end else begin
            load_cnt <= load_cnt + 4'd1;
          end
        end
        CHECK: begin
          // Feed back the prediction so that one line error stays a single error
          lfsr <= {lfsr[7:0], pred};
          if (win_cnt == WW'(LOCK_WINDOW - 1)) begin
            win_cnt <= '0;
            win_err <= '0;
            if (err_tot <= (WW+1)'(LOCK_ERR_MAX)) begin
              lock <= 1'b1;
            end else begin
              lock  <= 1'b0;
              state <= LOAD;
            end
          end else begin
            win_cnt <= win_cnt + WW'(1);
            win_err <= err_tot[WW-1:0];
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

module rx_prbs_ber_checker #(
  parameter int NB_INPUT     = 8,
  parameter int OS_FACTOR    = 4,
  parameter int NB_COUNT     = 64,
  parameter int LOCK_WINDOW  = 511,
  parameter int LOCK_ERR_MAX = 32
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic [1:0]                 i_phase,
  input  logic                       i_clear,
  input  logic signed [NB_INPUT-1:0] i_rx_symbI,
  input  logic signed [NB_INPUT-1:0] i_rx_symbQ,
  output logic [1:0]                 o_lock,
  output logic [NB_COUNT-1:0]        o_bit_cnt,
  output logic [NB_COUNT-1:0]        o_err_cntI,
  output logic [NB_COUNT-1:0]        o_err_cntQ
);

  localparam int NUM_LANES = 2;
  localparam int PW        = (OS_FACTOR > 1) ? $clog2(OS_FACTOR) : 1;
  localparam int STAGES    = 1;

  // Stage that feeds the counters: lock state at the decision and per-lane miss
  typedef struct packed {
    logic                 both_lk;
    logic [NUM_LANES-1:0] mis;
  } cnt_req_t;

  logic [NUM_LANES-1:0][NB_INPUT-1:0] samp;
  logic [PW-1:0]                      phase_cnt;
  logic                               strobe;
  logic [STAGES:0]                    vld_pipe;
  logic [NUM_LANES-1:0]               dec_bit;
  logic [NUM_LANES-1:0]               mis;
  cnt_req_t                           cnt_req;
  logic [NB_COUNT-1:0]                bit_cnt;
  logic [NUM_LANES-1:0][NB_COUNT-1:0] err_cnt;
  logic                               unused_bits;

  assign samp        = {i_rx_symbQ, i_rx_symbI};
  assign unused_bits = ^{i_rx_symbI[NB_INPUT-2:0], i_rx_symbQ[NB_INPUT-2:0]};

  function automatic logic [NB_COUNT-1:0] cnt_inc(input logic [NB_COUNT-1:0] v);
`ifdef RX_BER_SAT_EN
    return (v == {NB_COUNT{1'b1}}) ? v : v + NB_COUNT'(1);
`else
    return v + NB_COUNT'(1);
`endif
  endfunction

  // A phase value of OS_FACTOR or above never matches the counter, so no strobe is produced
  assign strobe = i_enable && (32'(phase_cnt) == 32'(i_phase));

  // Phase counter that runs modulo OS_FACTOR while enabled
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)
      phase_cnt <= '0;
    else if (i_enable)
      phase_cnt <= (phase_cnt == PW'(OS_FACTOR - 1)) ? '0 : phase_cnt + PW'(1);
  end

  // Slice on the strobe, then carry validity down to the count stage
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      vld_pipe <= '0;
      dec_bit  <= '0;
      cnt_req  <= '0;
    end else if (i_enable) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], strobe};
      if (strobe)
        for (int l = 0; l < NUM_LANES; l++) dec_bit[l] <= samp[l][NB_INPUT-1];
      cnt_req.both_lk <= &o_lock;
      cnt_req.mis     <= mis;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    rx_prbs_ber_branch #(
      .LOCK_WINDOW  (LOCK_WINDOW),
      .LOCK_ERR_MAX (LOCK_ERR_MAX)
    ) u_branch (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_enable (i_enable),
      .dec_vld  (vld_pipe[0]),
      .rx_bit   (dec_bit[l]),
      .lock     (o_lock[l]),
      .mis      (mis[l])
    );
  end

  // BER counters. Clear overrides any increment in the same cycle and does not depend on enable
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      bit_cnt <= '0;
      err_cnt <= '0;
    end else if (i_clear) begin
      bit_cnt <= '0;
      err_cnt <= '0;
    end else if (i_enable && vld_pipe[STAGES] && cnt_req.both_lk) begin
      bit_cnt <= cnt_inc(bit_cnt);
      for (int l = 0; l < NUM_LANES; l++)
        if (cnt_req.mis[l]) err_cnt[l] <= cnt_inc(err_cnt[l]);
    end
  end

  assign o_bit_cnt  = bit_cnt;
  assign o_err_cntI = err_cnt[0];
  assign o_err_cntQ = err_cnt[1];

endmodule

// File: tb/tb_rx_prbs_ber_checker.sv
// Directed bench for rx_prbs_ber_checker: lock acquisition, error injection,
// clear priority, enable freeze, reset, a branch that never locks, and
// counter overflow on a 4-bit instance.
module tb_rx_prbs_ber_checker;

  localparam int PH = 2;

  logic              clk = 1'b0;
  logic              rst_n, en, clr, clr4;
  logic [1:0]        phase;
  logic signed [7:0] si, sq;
  logic [1:0]        lock, lock4;
  logic [63:0]       bc, ei, eq;
  logic [3:0]        bc4, ei4, eq4;

  int n_vec = 0;
  int n_err = 0;
  logic [8:0] g_i = 9'h1A5;
  logic [8:0] g_q = 9'h0F3;

  always #5 clk = ~clk;

  rx_prbs_ber_checker dut (
    .i_clock(clk), .i_reset(rst_n), .i_enable(en), .i_phase(phase), .i_clear(clr),
    .i_rx_symbI(si), .i_rx_symbQ(sq), .o_lock(lock), .o_bit_cnt(bc),
    .o_err_cntI(ei), .o_err_cntQ(eq)
  );

  rx_prbs_ber_checker #(.NB_COUNT(4)) dut4 (
    .i_clock(clk), .i_reset(rst_n), .i_enable(en), .i_phase(phase), .i_clear(clr4),
    .i_rx_symbI(si), .i_rx_symbQ(sq), .o_lock(lock4), .o_bit_cnt(bc4),
    .o_err_cntI(ei4), .o_err_cntQ(eq4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_vec++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
    end
  endtask

  // One symbol of OS=4 clocks. The chosen phase carries the true level; the
  // other phases carry the opposite level, so a wrong decimation phase is visible.
  task automatic symbol(input bit f_i, input bit f_q, input bit c, input bit c4);
    logic b_i, b_q;
    b_i = g_i[8] ^ g_i[4]; g_i = {g_i[7:0], b_i};
    b_q = g_q[8] ^ g_q[4]; g_q = {g_q[7:0], b_q};
    b_i = b_i ^ f_i;
    b_q = b_q ^ f_q;
    for (int k = 0; k < 4; k++) begin
      clr  = (k == 0) ? c  : 1'b0;
      clr4 = (k == 0) ? c4 : 1'b0;
      if (k == PH) begin
        si = b_i ? -8'sd100 : 8'sd100;
        sq = b_q ? -8'sd100 : 8'sd100;
      end else begin
        si = b_i ? 8'sd90 : -8'sd90;
        sq = b_q ? 8'sd90 : -8'sd90;
      end
      @(posedge clk); #1;
    end
    clr = 1'b0; clr4 = 1'b0;
  endtask

  task automatic run(input int n, input bit f_i);
    repeat (n) symbol(f_i, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; clr4 = 1'b0; phase = 2'(PH); si = '0; sq = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lock", lock, 0);
    chk("rst_bit",  bc, 0);
    chk("rst_errI", ei, 0);
    chk("rst_errQ", eq, 0);
    rst_n = 1'b1;

    // Lock is granted after 9 load decisions plus one clean 511-decision window
    run(519, 1'b0);
    chk("lock_519", lock, 0);
    run(1, 1'b0);
    chk("lock_520", lock, 3);
    chk("bit_520",  bc, 0);
    run(10, 1'b0);                        // 530 decisions
    chk("bit_530",  bc, 9);
    chk("errI_530", ei, 0);
    chk("errQ_530", eq, 0);

    // 4-bit instance: clear, then 20 clean counted decisions
    symbol(1'b0, 1'b0, 1'b0, 1'b1);       // 531
    run(20, 1'b0);                        // 551
`ifdef RX_BER_SAT_EN
    chk("bit4_sat", bc4, 15);
`else
    chk("bit4_wrap", bc4, 4);
`endif
    chk("errI4", ei4, 0);
    chk("errQ4", eq4, 0);
    chk("lock4", lock4, 3);
    chk("bit_551", bc, 30);

    // Single I error
    symbol(1'b1, 1'b0, 1'b0, 1'b0);       // 552
    symbol(1'b0, 1'b0, 1'b0, 1'b0);       // 553
    chk("errI_one", ei, 1);
    chk("errQ_none", eq, 0);
    chk("bit_553", bc, 32);
    run(7, 1'b0);                         // 560
    chk("errI_hold", ei, 1);
    chk("lock_held", lock, 3);

    // Clear on the cycle where an error count is pending
    symbol(1'b1, 1'b0, 1'b0, 1'b0);       // 561
    symbol(1'b0, 1'b0, 1'b1, 1'b0);       // 562, clear
    chk("clr_bit",  bc, 0);
    chk("clr_errI", ei, 0);
    chk("clr_errQ", eq, 0);
    symbol(1'b0, 1'b0, 1'b0, 1'b0);       // 563
    chk("resume_bit", bc, 1);
    run(7, 1'b0);                         // 570
    chk("bit_570", bc, 8);

    // Single Q error
    symbol(1'b0, 1'b1, 1'b0, 1'b0);       // 571
    symbol(1'b0, 1'b0, 1'b0, 1'b0);       // 572
    chk("errQ_one", eq, 1);
    chk("errI_zero", ei, 0);
    chk("bit_572", bc, 10);

    // Enable low freezes everything, including a count still in flight
    en = 1'b0;
    repeat (10) begin
      si = 8'($urandom); sq = 8'($urandom);
      @(posedge clk); #1;
    end
    chk("frz_bit", bc, 10);
    chk("frz_lock", lock, 3);
    en = 1'b1;
    symbol(1'b0, 1'b0, 1'b0, 1'b0);       // 573
    chk("unfrz_bit", bc, 11);

    // Reset in the middle of a run takes effect immediately
    rst_n = 1'b0;
    #1;
    chk("mid_rst_lock", lock, 0);
    chk("mid_rst_bit",  bc, 0);
    chk("mid_rst_errI", ei, 0);
    chk("mid_rst_errQ", eq, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Inverted I stream never satisfies the recurrence; Q locks on its own
    run(519, 1'b1);
    chk("inv_lock_519", lock, 0);
    run(1, 1'b1);
    chk("inv_lock_520", lock, 2);
    run(580, 1'b1);
    chk("inv_lock_1100", lock, 2);
    chk("inv_bit", bc, 0);
    chk("inv_errI", ei, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
